fir_mac_lpf: RTL and testbench

//  Next-generation SDR receive low-pass FIR: parametrised tap count, data and coefficient widths.

---
 rtl/fir_mac_lpf.sv | 187 ++++++++++++++++++
 tb/tb_fir_mac_lpf.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_lpf.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_lpf
// Description : Receive-path low-pass FIR filter. One multiply-accumulate
//               unit is shared across all taps, one tap per enabled cycle.
//               Coefficients live in a RAM that can be rewritten at run time.
//               The sum is rounded half-up, then saturated to OUT_W bits.
//               Input uses a valid/ready handshake.
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous, active-high
//               clk_enable - 1 = advance, 0 = freeze all state
//               in_valid   - in_data carries a sample
//               in_ready   - a sample can be accepted (FSM idle)
//               in_data    - signed input sample
//               coef_we    - coefficient write strobe (honoured only when idle)
//               coef_addr  - tap index; indices >= NTAPS are ignored
//               coef_wdata - signed coefficient value
//               out_valid  - one-cycle strobe marking a new out_data
//               out_data   - filtered sample, held until the next result
//               sat_flag   - out_data was clamped
//               busy       - a MAC sweep is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_lpf #(
    parameter  int NTAPS     = 26,
    parameter  int DATA_W    = 10,
    parameter  int COEF_W    = 18,
    parameter  int ACC_W     = 34,
    parameter  int OUT_SHIFT = 16,
    parameter  int OUT_W     = 10,
    localparam int ADDR_W    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_we,
    input  logic        [ADDR_W-1:0] coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     sat_flag,
    output logic                     busy
);

    localparam int c_PROD_W = DATA_W + COEF_W;
    // One guard bit above the accumulator so that adding the rounding
    // constant can never wrap.
    localparam int c_EXT_W  = ACC_W + 1;

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NTAPS - 1);

    localparam logic signed [c_EXT_W-1:0] c_HALF    = c_EXT_W'(64'sd1 <<< (OUT_SHIFT - 1));
    localparam logic signed [c_EXT_W-1:0] c_OUT_MAX = c_EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [c_EXT_W-1:0] c_OUT_MIN = c_EXT_W'(-(64'sd1 <<< (OUT_W - 1)));

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MAC  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;

    logic signed [DATA_W-1:0] r_ring [NTAPS];
    logic signed [COEF_W-1:0] r_coef [NTAPS];
    logic [ADDR_W-1:0]        r_wptr;
    logic [ADDR_W-1:0]        r_rptr;   // ring slot of tap k: (base - k) mod NTAPS
    logic [ADDR_W-1:0]        r_k;
    logic signed [ACC_W-1:0]  r_acc;

    logic                     w_last_tap;
    logic                     w_coef_wr;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [c_EXT_W-1:0] w_acc_ext;
    logic signed [c_EXT_W-1:0] w_rnd;
    logic signed [c_EXT_W-1:0] w_shr;

    assign w_last_tap = (r_k == c_LAST);
    assign w_coef_wr  = clk_enable && coef_we && (r_state == c_IDLE) && (coef_addr <= c_LAST);

    // Full-precision signed product, sign-extended into the accumulator.
    assign w_prod     = r_ring[r_rptr] * r_coef[r_k];
    assign w_prod_ext = ACC_W'(w_prod);

    // Round half toward +inf, then arithmetic shift down.
    assign w_acc_ext  = c_EXT_W'(r_acc);
    assign w_rnd      = w_acc_ext + c_HALF;
    assign w_shr      = w_rnd >>> OUT_SHIFT;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else if (clk_enable) begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)   w_state_next = c_MAC;
            c_MAC:   if (w_last_tap) w_state_next = c_DONE;
            c_DONE:                  w_state_next = c_IDLE;
            default:                 w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (r_state == c_IDLE);
        busy     = (r_state != c_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_ring[i] <= '0;
                r_coef[i] <= '0;
            end
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else if (clk_enable) begin
            // The strobe lasts exactly one enabled cycle.
            out_valid <= (r_state == c_DONE);

            // The coefficient write lands on the accept edge, so the sweep
            // that starts next already sees the new value.
            if (w_coef_wr) begin
                r_coef[coef_addr] <= coef_wdata;
            end

            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_ring[r_wptr] <= in_data;
                        r_rptr         <= r_wptr;
                        r_wptr         <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
                        r_acc          <= '0;
                        r_k            <= '0;
                    end
                end
                c_MAC: begin
                    r_acc  <= r_acc + w_prod_ext;
                    r_rptr <= (r_rptr == '0) ? c_LAST : r_rptr - 1'b1;
                    if (!w_last_tap) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                c_DONE: begin
                    if (w_shr > c_OUT_MAX) begin
                        out_data <= c_OUT_MAX[OUT_W-1:0];
                        sat_flag <= 1'b1;
                    end else if (w_shr < c_OUT_MIN) begin
                        out_data <= c_OUT_MIN[OUT_W-1:0];
                        sat_flag <= 1'b1;
                    end else begin
                        out_data <= w_shr[OUT_W-1:0];
                        sat_flag <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_lpf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_lpf
// Description : Self-checking bench for fir_mac_lpf. A sliding-window
//               reference model (sample history plus coefficient array,
//               plain integer arithmetic) predicts every output value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_lpf;

    localparam int NTAPS     = 26;
    localparam int DATA_W    = 10;
    localparam int COEF_W    = 18;
    localparam int ACC_W     = 34;
    localparam int OUT_SHIFT = 16;
    localparam int OUT_W     = 10;
    localparam int ADDR_W    = 5;
    localparam int LAT       = NTAPS + 1;

    logic                     clk;
    logic                     reset;
    logic                     clk_enable;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_we;
    logic        [ADDR_W-1:0] coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     sat_flag;
    logic                     busy;

    int checks = 0;
    int errors = 0;

    longint m_coef [NTAPS];
    longint m_hist [NTAPS];   // m_hist[0] is the newest sample

    fir_mac_lpf #(
        .NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
        .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < NTAPS; i++) begin
            m_coef[i] = 0;
            m_hist[i] = 0;
        end
    endtask

    task automatic model_push(input longint x);
        for (int i = NTAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = x;
    endtask

    task automatic model_write(input int addr, input longint v);
        if (addr < NTAPS) m_coef[addr] = v;
    endtask

    task automatic model_expect(output logic signed [OUT_W-1:0] od, output logic sf);
        longint acc, r, hi, lo;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) acc += m_hist[k] * m_coef[k];
        r  = (acc + (64'sd1 <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
        hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        lo = -(64'sd1 <<< (OUT_W - 1));
        sf = 1'b0;
        if (r > hi) begin r = hi; sf = 1'b1; end
        if (r < lo) begin r = lo; sf = 1'b1; end
        od = OUT_W'(r);
    endtask

    // ---------------- stimulus helpers (time always left at a negedge) ----------------
    task automatic write_coef(input int a, input longint v);
        coef_we    = 1'b1;
        coef_addr  = ADDR_W'(a);
        coef_wdata = COEF_W'(v);
        @(negedge clk);
        coef_we    = 1'b0;
        model_write(a, v);
    endtask

    task automatic fill_coef(input longint v);
        for (int i = 0; i < NTAPS; i++) write_coef(i, v);
    endtask

    // Offers one sample, then waits for its result. Optional: coincident
    // coefficient write, clk_enable stall window, coefficient write while busy.
    task automatic do_sample(input longint x, input bit wr, input int wa, input longint wv,
                             input int stall_at, input int stall_len, input bit busy_wr,
                             output logic signed [OUT_W-1:0] od, output logic sf, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
        in_valid = 1'b1;
        in_data  = DATA_W'(x);
        if (wr) begin
            coef_we = 1'b1; coef_addr = ADDR_W'(wa); coef_wdata = COEF_W'(wv);
        end
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (wr) model_write(wa, wv);
        model_push(x);
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (stall_len > 0 && lat == stall_at) begin
                clk_enable = 1'b0;
                repeat (stall_len) begin @(negedge clk); lat++; end
                clk_enable = 1'b1;
            end else begin
                if (busy_wr && lat == 3) begin
                    coef_we = 1'b1; coef_addr = '0; coef_wdata = COEF_W'(18'h1ABCD);
                end
                @(negedge clk);
                lat++;
                coef_we = 1'b0;
            end
        end
        if (!out_valid) lat = -1;
        od = out_data;
        sf = sat_flag;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
    endtask

    task automatic test_step();
        logic signed [OUT_W-1:0] od;
        logic sf;
        int lat, want;
        fill_coef(2048);
        for (int n = 1; n <= 30; n++) begin
            do_sample(256, 0, 0, 0, 0, 0, 0, od, sf, lat);
            want = (n <= NTAPS) ? 8 * n : 8 * NTAPS;
            checks++; if (od !== OUT_W'(want)) begin errors++; $display("FAIL step_out n=%0d got %0d want %0d", n, od, want); end
            checks++; if (lat != LAT) begin errors++; $display("FAIL step_latency n=%0d got %0d want %0d", n, lat, LAT); end
            checks++; if (sf !== 1'b0) begin errors++; $display("FAIL step_sat n=%0d got %b want 0", n, sf); end
            // Next sample may be accepted while out_valid is high.
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL step_ready_with_valid n=%0d got %b want 1", n, in_ready); end
        end
    endtask

    task automatic test_saturation();
        logic signed [OUT_W-1:0] od, eod;
        logic sf, esf;
        int lat;
        fill_coef(65536);
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < NTAPS; n++) begin
                do_sample(pass == 0 ? 511 : -512, 0, 0, 0, 0, 0, 0, od, sf, lat);
                model_expect(eod, esf);
                checks++; if (od !== eod || sf !== esf) begin errors++; $display("FAIL sat_model pass=%0d n=%0d got %0d/%b want %0d/%b", pass, n, od, sf, eod, esf); end
            end
            checks++; if (od !== (pass == 0 ? 10'sd511 : -10'sd512) || sf !== 1'b1) begin
                errors++; $display("FAIL sat_final pass=%0d got %0d/%b want %0d/1", pass, od, sf, pass == 0 ? 511 : -512);
            end
        end
    endtask

    task automatic test_rounding();
        logic signed [OUT_W-1:0] od;
        logic sf;
        int lat;
        longint ins  [3] = '{3, -3, 2};
        longint outs [3] = '{2, -1, 1};
        write_coef(0, 32768);
        for (int i = 1; i < NTAPS; i++) write_coef(i, 0);
        for (int i = 0; i < 3; i++) begin
            do_sample(ins[i], 0, 0, 0, 0, 0, 0, od, sf, lat);
            checks++; if (od !== OUT_W'(outs[i]) || sf !== 1'b0) begin
                errors++; $display("FAIL round in=%0d got %0d/%b want %0d/0", ins[i], od, sf, outs[i]);
            end
        end
    endtask

    task automatic test_stalls();
        logic signed [OUT_W-1:0] od, eod, held;
        logic sf, esf;
        int lat, n;
        for (int i = 0; i < NTAPS; i++) write_coef(i, longint'($urandom_range(0, 4000)) - 2000);

        // Sample B held on the input while A is being processed.
        in_valid = 1'b1; in_data = 10'sd77;
        @(negedge clk);
        model_push(77);
        model_expect(eod, esf);
        in_data = -10'sd150;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        checks++; if (n != LAT) begin errors++; $display("FAIL hold_ready_return got %0d want %0d", n, LAT); end
        checks++; if (out_valid !== 1'b1 || out_data !== eod) begin errors++; $display("FAIL hold_first_out got %0d/%b want %0d/1", out_data, out_valid, eod); end
        @(negedge clk);
        in_valid = 1'b0;
        model_push(-150);
        model_expect(eod, esf);
        lat = 0;
        while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
        checks++; if (lat != LAT || out_data !== eod) begin errors++; $display("FAIL hold_second_out got %0d lat %0d want %0d lat %0d", out_data, lat, eod, LAT); end

        // clk_enable dropped for 5 cycles mid-MAC.
        do_sample(-301, 0, 0, 0, 10, 5, 0, od, sf, lat);
        model_expect(eod, esf);
        checks++; if (lat != LAT + 5) begin errors++; $display("FAIL stall_latency got %0d want %0d", lat, LAT + 5); end
        checks++; if (od !== eod || sf !== esf) begin errors++; $display("FAIL stall_value got %0d/%b want %0d/%b", od, sf, eod, esf); end

        // Strobe stretches while frozen, then drops on the next enabled edge.
        held = out_data;
        clk_enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("FAIL freeze_hold got %b/%0d want 1/%0d", out_valid, out_data, held); end
        clk_enable = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL strobe_drop got %b want 0", out_valid); end

        // Write while busy is ignored.
        do_sample(200, 0, 0, 0, 0, 0, 1, od, sf, lat);
        do_sample(-5, 0, 0, 0, 0, 0, 0, od, sf, lat);
        model_expect(eod, esf);
        checks++; if (od !== eod || sf !== esf) begin errors++; $display("FAIL busy_write_ignored got %0d/%b want %0d/%b", od, sf, eod, esf); end

        // Out-of-range address ignored; coincident write + accept uses new value.
        write_coef(28, 9999);
        do_sample(123, 1, 0, 60000, 0, 0, 0, od, sf, lat);
        model_expect(eod, esf);
        checks++; if (od !== eod || sf !== esf) begin errors++; $display("FAIL write_with_accept got %0d/%b want %0d/%b", od, sf, eod, esf); end
    endtask

    task automatic test_reset_mid();
        logic signed [OUT_W-1:0] od;
        logic sf;
        int lat, seen;
        in_valid = 1'b1; in_data = 10'sd300;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_valid got %0d strobes want 0", seen); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            errors++; $display("FAIL abort_state got busy=%b ready=%b out=%0d want 0/1/0", busy, in_ready, out_data);
        end
        write_coef(0, 65536);
        do_sample(100, 0, 0, 0, 0, 0, 0, od, sf, lat);
        checks++; if (od !== 10'sd100 || sf !== 1'b0 || lat != LAT) begin
            errors++; $display("FAIL abort_impulse got %0d/%b lat %0d want 100/0 lat %0d", od, sf, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic signed [OUT_W-1:0] od, eod;
        logic sf, esf;
        logic signed [COEF_W-1:0] cv;
        logic signed [DATA_W-1:0] dv;
        int lat;
        bit wr;
        for (int i = 0; i < NTAPS + 4; i++) begin
            cv = COEF_W'($urandom);
            cv = cv >>> $urandom_range(0, 7);
            write_coef(i, longint'(cv));
        end
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            dv = DATA_W'($urandom);
            cv = COEF_W'($urandom) >>> 4;
            wr = ($urandom_range(0, 3) == 0);
            do_sample(longint'(dv), wr, $urandom_range(0, 31), longint'(cv), 0, 0, 0, od, sf, lat);
            model_expect(eod, esf);
            checks++; if (od !== eod || sf !== esf || lat != LAT) begin
                errors++; $display("FAIL random n=%0d got %0d/%b lat %0d want %0d/%b lat %0d", n, od, sf, lat, eod, esf, LAT);
            end
        end
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_step();
        test_saturation();
        test_rounding();
        test_stalls();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
